// File: rtl/regfile_mp_sb_if.sv
// Bundles the register-file bus: write ports, read ports and scoreboard set.
// Packed vectors carry port i at [i*W +: W].
interface regfile_mp_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     sb_set_en;
    logic [ADDR_W-1:0]        sb_set_addr;
    logic                     busy_any;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, sb_set_en, sb_set_addr,
        input  rd_data, rd_busy, busy_any
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, sb_set_en, sb_set_addr,
        output rd_data, rd_busy, busy_any
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with same-cycle write-to-read bypass and a
// per-register pending-write scoreboard; r0 is hardwired to zero.
module regfile_mp_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    regfile_mp_sb_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0]  busy_reg;
    logic [DEPTH-1:0]  busy_next;
    logic [ADDR_W-1:0] wa [NUM_WR];
    logic [DATA_W-1:0] wd [NUM_WR];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WR; gi++) begin : g_wr
            assign wa[gi] = bus.wr_addr[gi*ADDR_W +: ADDR_W];
            assign wd[gi] = bus.wr_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Ascending port order makes the highest-index enabled port win a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) regs_reg[r] <= '0;
            busy_reg <= '0;
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (bus.wr_en[i] && wa[i] != '0) regs_reg[wa[i]] <= wd[i];
            end
            busy_reg <= busy_next;
        end
    end

    // Clears are applied before the set so a new producer keeps the bit pending.
    always_comb begin
        busy_next = busy_reg;
        for (int i = 0; i < NUM_WR; i++) begin
            if (bus.wr_en[i]) busy_next[wa[i]] = 1'b0;
        end
        if (bus.sb_set_en) busy_next[bus.sb_set_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    assign bus.busy_any = |busy_reg;

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic              hit;
            logic [DATA_W-1:0] byp;

            assign ra = bus.rd_addr[gi*ADDR_W +: ADDR_W];

            always_comb begin
                hit = 1'b0;
                byp = regs_reg[ra];
                for (int i = 0; i < NUM_WR; i++) begin
                    if (bus.wr_en[i] && wa[i] == ra) begin
                        hit = 1'b1;
                        byp = wd[i];
                    end
                end
            end

            // Gating with rst_n keeps bypassed data off the outputs during reset.
            assign bus.rd_data[gi*DATA_W +: DATA_W] = (rst_n && ra != '0) ? byp : '0;
            assign bus.rd_busy[gi] = rst_n && (ra != '0) && busy_reg[ra] && !hit;
        end
    endgenerate
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port register file for the pipelined core.
- Supports configurable width, depth, read-port count and write-port count.
- Adds write-to-read bypass, asynchronous clear, and a per-register pending-write scoreboard for hazard detection.
- Sits between decode/issue (read ports, scoreboard set) and writeback (write ports, scoreboard clear).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W registers including r0.
- NUM_RD, 2, number of read ports, >=1.
- NUM_WR, 2, number of write ports, >=1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  NUM_WR  per-port write enable.
- wr_addr  input  NUM_WR*ADDR_W  write addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- wr_data  input  NUM_WR*DATA_W  write data, packed the same way as wr_addr.
- rd_addr  input  NUM_RD*ADDR_W  read addresses, packed.
- rd_data  output  NUM_RD*DATA_W  read data, packed.
- rd_busy  output  NUM_RD  per read port: addressed register still has a pending write.
- sb_set_en  input  1  issue marks a destination register as pending.
- sb_set_addr  input  ADDR_W  destination register being marked.
- busy_any  output  1  OR of all busy bits.

Behaviour:
- Reset:
  - Clock and reset are decided: one clock named clk; reset is asynchronous and active-low, named rst_n.
  - rst_n low immediately clears all registers to 0 and all busy bits to 0, independent of clk.
  - While rst_n is low: rd_data reads 0 on every port, rd_busy=0, busy_any=0.
  - Deassertion takes effect at the next rising clk edge. No write or scoreboard update occurs on the edge coincident with rst_n low.
- Register 0:
  - Hardwired 0; writes to address 0 are ignored.
  - Busy bit 0 is never set; sb_set_en with address 0 is a no-op.
  - rd_data is always 0 and rd_busy always 0 for address 0, including under bypass.
- Write (sequential):
  - On posedge clk, each port i with wr_en[i]=1 and wr_addr_i!=0 writes wr_data_i.
  - Same-cycle collision on one address: the highest-index enabled port wins; the other ports' data is discarded.
- Read (combinational, zero latency):
  - rd_data_j = 0 if rd_addr_j==0.
  - Otherwise, if any enabled write port targets rd_addr_j this cycle: that port's wr_data. Use the highest-index matching port, consistent with the collision rule.
  - Otherwise the stored value.
  - The bypass makes a write visible in the same cycle. Stored state updates at the edge.
- Scoreboard, one busy bit per register 1..2**ADDR_W-1:
  - Clear: on posedge, any enabled write to address a clears busy[a].
  - Set: on posedge, sb_set_en sets busy[sb_set_addr].
  - Set and clear on the same address in the same cycle: set wins, so the bit remains 1. This covers a new producer issuing while the old one writes back.
  - rd_busy_j = busy[rd_addr_j] AND NOT (an enabled write to rd_addr_j this cycle). A writeback in the same cycle resolves the hazard via bypass.
  - A same-cycle sb_set does not affect rd_busy. The issuing instruction reads its sources before its own destination becomes pending.
  - Setting an already-busy bit: stays 1; no counting or error is raised.
  - Clearing a non-busy bit via a write: stays 0; the write still proceeds.
  - busy_any = OR of the registered busy bits; it does not include same-cycle set or clear.
- Arithmetic/width:
  - No arithmetic; addresses are compared at full ADDR_W.
  - Out-of-range addresses do not exist, since depth = 2**ADDR_W.
- Implementation:
  - Generate loops over NUM_RD and NUM_WR.
  - No X propagation on any output after reset.

Test Plan:
- Reset mid-operation: write r5=0xDEADBEEF and set busy r7, then pulse rst_n low between edges.
  - Immediately: rd r5 = 0, rd_busy(r7) = 0, busy_any = 0.
  - After release: r5 still reads 0.
- r0 and write collision:
  - Write r0=0x1234 -> reads 0.
  - Ports 0 and 1 both write r3 (0xAAAA, 0x5555) in one cycle -> next cycle r3 = 0x5555; same-cycle bypass read of r3 = 0x5555.
- Bypass on all read ports: with r9=0x11 stored, drive a write r9=0x22 and read r9 on both read ports in the same cycle -> both rd_data = 0x22; next cycle r9 = 0x22.
- Scoreboard set then clear:
  - sb_set r4 -> next cycle rd_busy(r4)=1, busy_any=1.
  - In the writeback cycle to r4: rd_busy(r4)=0 and rd_data = new data.
  - Afterwards busy_any=0.
- Simultaneous set/clear: r6 busy, writeback to r6 and sb_set r6 in the same cycle -> that cycle rd_busy(r6)=0; next cycle rd_busy(r6)=1.
- Parameter sweep: DATA_W=64, ADDR_W=3, NUM_RD=3, NUM_WR=1 -> write then read all 7 nonzero registers with random data; all 3 ports match; r0=0.
